cpu_fetch_unit: RTL and testbench
=================================

Name: cpu_fetch_unit

Overview:
- Instruction fetch front-end that feeds cpu_controller's decode/execute path.
- Issues word reads to instruction memory over a req/ack handshake, with one request outstanding at most.
- Buffers returned instructions and their PCs in a small prefetch queue.
- Presents them to the controller over a valid/ready interface.
- Handles control-flow redirects (branch/jump/exception) by flushing the queue and discarding in-flight data.

Parameters:
- ADDR_W, 32, address/PC width.
- INST_W, 32, instruction word width.
- DEPTH, 4, prefetch queue entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  word-aligned read address.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  INST_W  returned instruction word.
- redirect_valid  in  1  one-cycle pulse; discard all fetched state and restart.
- redirect_pc  in  ADDR_W  new fetch address; bits[1:0] forced to 0.
- inst_valid  out  1  queue head valid.
- inst_data  out  INST_W  queue head instruction.
- inst_pc  out  ADDR_W  PC of queue head.
- inst_ready  in  1  controller consumes head when inst_valid&&inst_ready.

Behaviour:
- Reset (async, immediate): mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, queue count=0, fetch_pc=RESET_PC, state=IDLE.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: mem_req=1, mem_addr=fetch_pc held stable until ack.
  - DISCARD: request outstanding but its data is void; mem_req stays 1, mem_addr unchanged until ack.
- Room rule: count_next = count + push - pop. A new request may issue at an edge only if count_next < DEPTH.
- IDLE -> REQ at an edge when room holds. First edge after rst deasserts gives mem_req=1, mem_addr=RESET_PC.
- REQ with mem_ack:
  - Push {fetch_pc, mem_rdata}; fetch_pc += 4, wrapping modulo 2^ADDR_W.
  - If room, stay REQ with the new mem_addr, so mem_req remains high back-to-back. Otherwise go to IDLE with mem_req=0.
- REQ without ack: hold state and outputs.
- Memory may ack in the first cycle mem_req is high.
- Stray mem_ack in IDLE is ignored.
- Queue output is registered: an ack at edge N gives inst_valid=1 in the cycle after N, i.e. one cycle of latency, when the queue was empty.
- Queue is FIFO-ordered. Simultaneous push and pop leaves count unchanged. No push when full (guaranteed by room rule).
- redirect_valid at an edge:
  - Queue flushed: count=0, inst_valid=0 next cycle. A pop in the same cycle is ignored.
  - fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - In REQ without ack -> DISCARD.
  - In REQ with ack in the same cycle -> ack data dropped, then -> REQ at redirect target.
  - In IDLE -> REQ at redirect target.
- DISCARD:
  - On mem_ack: drop data, -> REQ with mem_addr=fetch_pc (room is guaranteed, queue is empty).
  - A further redirect while in DISCARD only updates fetch_pc.
- inst_data/inst_pc are don't-care when inst_valid=0. Implementation drives the head entry.

Decomposition:
- Package cpu_defs: ADDR_W, INST_W, RESET_PC, the fetch_state_t enum (IDLE, REQ, DISCARD), and the PC increment constant 4.
- Sub-module cpu_fetch_queue: synchronous FIFO holding {pc, inst}, with push, pop, flush, count, and full/empty. It uses the same asynchronous rst.
- The FSM and PC logic stay in cpu_fetch_unit.

Test Plan:
1. Sequential fetch: rst pulse, then ack every cycle with mem_rdata=addr^32'hA5A5_0000, inst_ready=1 -> mem_addr 0x0,0x4,0x8,0xC... consecutive cycles; inst_pc/inst_data match in order; first inst_valid one cycle after first ack.
2. Backpressure: inst_ready=0, ack every cycle -> exactly 4 pushes (0x0..0xC), then mem_req=0. Raise inst_ready for 1 cycle -> head 0x0 pops, mem_req=1 with addr 0x10.
3. Redirect in flight: mem_req high at 0x8 with no ack, redirect_pc=0x100 -> inst_valid=0 next cycle, state DISCARD. Later ack with 0xDEADBEEF is never presented; next mem_addr=0x100.
4. Redirect coincident with ack, redirect_pc=0x102 -> ack data dropped, next mem_addr=0x100, first presented inst_pc=0x100.
5. Wrap: redirect_pc=0xFFFF_FFFC, ack twice -> inst_pc 0xFFFF_FFFC then 0x0000_0000.
6. Async reset mid-request: assert rst between edges while mem_req=1 -> mem_req=0 and inst_valid=0 immediately. An ack during/after reset while IDLE is ignored; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   ADDR_W / INST_W : PC and instruction word widths
//   RESET_PC        : default first fetch address after reset
//   PC_INC          : sequential fetch stride in bytes
//   fetch_state_t   : fetch FSM states
//   fetch_entry_t   : one prefetch queue entry {pc, inst}
package cpu_defs;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory req/ack port, redirect input,
// and the valid/ready instruction port towards the controller.
//   master : fetch unit side
//   slave  : memory/controller side
interface cpu_fetch_unit_if;
  import cpu_defs::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/cpu_fetch_unit_queue.sv
// Prefetch FIFO holding {pc, inst} entries.
//   clk, rst    : clock, asynchronous active-high reset
//   push, din   : write an entry (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   flush       : empty the queue; overrides push/pop
//   head        : current head entry
//   count       : number of stored entries
//   full, empty : occupancy flags
module cpu_fetch_queue
  import cpu_defs::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               din,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch front-end: one outstanding word read to instruction
// memory, prefetch queue of {pc, inst}, valid/ready delivery to the
// controller, and flush/restart on redirect.
//   clk, rst : clock, asynchronous active-high reset
//   fif      : memory req/ack, redirect, and instruction valid/ready signals
module cpu_fetch_unit
  import cpu_defs::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  cpu_fetch_unit_if.master   fif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] redir_target;
  logic [ADDR_W-1:0] next_pc;
  logic              push;
  logic              pop;
  logic              room;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     count_next;
  logic              q_full;
  logic              q_empty;
  fetch_entry_t      q_head;
  fetch_entry_t      q_din;

  assign redir_target = {fif.redirect_pc[ADDR_W-1:2], 2'b00};
  assign next_pc      = fetch_pc + ADDR_W'(PC_INC);

  // A redirect voids both the returning data and any same-cycle pop.
  assign push = (state == REQ) && fif.mem_ack && !fif.redirect_valid && !q_full;
  assign pop  = fif.inst_valid && fif.inst_ready && !fif.redirect_valid;

  assign count_next = fif.redirect_valid ? '0 : (q_count + CW'(push) - CW'(pop));
  assign room       = (count_next < CW'(DEPTH));

  assign q_din = '{pc: fetch_pc, inst: fif.mem_rdata};

  cpu_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (q_din),
    .pop   (pop),
    .flush (fif.redirect_valid),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign fif.inst_valid = !q_empty;
  assign fif.inst_data  = q_head.inst;
  assign fif.inst_pc    = q_head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      fif.mem_req  <= 1'b0;
      fif.mem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (fif.redirect_valid) begin
            fetch_pc     <= redir_target;
            state        <= REQ;
            fif.mem_req  <= 1'b1;
            fif.mem_addr <= redir_target;
          end else if (room) begin
            state        <= REQ;
            fif.mem_req  <= 1'b1;
            fif.mem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (fif.redirect_valid) begin
            fetch_pc <= redir_target;
            if (fif.mem_ack) begin
              fif.mem_addr <= redir_target;
            end else begin
              // Request stays on the bus; its data will be dropped.
              state <= DISCARD;
            end
          end else if (fif.mem_ack) begin
            fetch_pc <= next_pc;
            if (room) begin
              fif.mem_addr <= next_pc;
            end else begin
              state       <= IDLE;
              fif.mem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (fif.redirect_valid) fetch_pc <= redir_target;
          if (fif.mem_ack) begin
            state        <= REQ;
            fif.mem_addr <= fif.redirect_valid ? redir_target : fetch_pc;
          end
        end
        default: begin
          state       <= IDLE;
          fif.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
module tb_cpu_fetch_unit;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic        rdata_force;
  logic [31:0] rdata_value;

  cpu_fetch_unit_if fif();

  cpu_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  always #5 clk = ~clk;

  // Memory model: returns address ^ A5A5_0000 unless a specific word is forced.
  always_comb begin
    fif.mem_rdata = rdata_force ? rdata_value : (fif.mem_addr ^ 32'hA5A5_0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fif.mem_ack = 1'b0;
    fif.inst_ready = 1'b0;
    fif.redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fif.mem_ack = 1'b0;
    fif.inst_ready = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc = '0;
    rdata_force = 1'b0;
    rdata_value = '0;

    // Reset state
    tick();
    chk("rst_mem_req", 32'(fif.mem_req), 32'd0);
    chk("rst_mem_addr", fif.mem_addr, 32'h0);
    chk("rst_inst_valid", 32'(fif.inst_valid), 32'd0);
    chk("rst_inst_data", fif.inst_data, 32'h0);
    chk("rst_inst_pc", fif.inst_pc, 32'h0);

    // 1. Sequential fetch
    rst = 1'b0;
    fif.mem_ack = 1'b1;
    fif.inst_ready = 1'b1;
    tick();
    chk("seq_first_req", 32'(fif.mem_req), 32'd1);
    chk("seq_first_addr", fif.mem_addr, 32'h0);
    chk("seq_no_valid_yet", 32'(fif.inst_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("seq_addr", fif.mem_addr, 32'(4 * k));
      chk("seq_valid", 32'(fif.inst_valid), 32'd1);
      chk("seq_pc", fif.inst_pc, 32'(4 * (k - 1)));
      chk("seq_data", fif.inst_data, 32'(4 * (k - 1)) ^ 32'hA5A5_0000);
    end

    // 2. Backpressure
    do_reset();
    fif.mem_ack = 1'b1;
    fif.inst_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("bp_req_before_full", 32'(fif.mem_req), 32'd1);
    chk("bp_addr_before_full", fif.mem_addr, 32'hC);
    tick();
    chk("bp_full_req_low", 32'(fif.mem_req), 32'd0);
    chk("bp_head_pc", fif.inst_pc, 32'h0);
    tick();
    chk("bp_stray_ack_ignored", 32'(fif.mem_req), 32'd0);
    fif.mem_ack = 1'b0;
    fif.inst_ready = 1'b1;
    tick();
    fif.inst_ready = 1'b0;
    chk("bp_reissue_req", 32'(fif.mem_req), 32'd1);
    chk("bp_reissue_addr", fif.mem_addr, 32'h10);
    chk("bp_next_head_pc", fif.inst_pc, 32'h4);
    chk("bp_next_head_data", fif.inst_data, 32'hA5A5_0004);

    // 3. Redirect with a request in flight
    do_reset();
    fif.inst_ready = 1'b1;
    tick();
    fif.mem_ack = 1'b1;
    tick();
    tick();
    fif.mem_ack = 1'b0;
    chk("rd_addr_before", fif.mem_addr, 32'h8);
    chk("rd_valid_before", 32'(fif.inst_valid), 32'd1);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'h100;
    tick();
    fif.redirect_valid = 1'b0;
    chk("rd_flush_valid", 32'(fif.inst_valid), 32'd0);
    chk("rd_discard_req", 32'(fif.mem_req), 32'd1);
    chk("rd_discard_addr", fif.mem_addr, 32'h8);
    tick();
    chk("rd_discard_hold", fif.mem_addr, 32'h8);
    fif.mem_ack = 1'b1;
    rdata_force = 1'b1;
    rdata_value = 32'hDEAD_BEEF;
    tick();
    rdata_force = 1'b0;
    chk("rd_void_not_shown", 32'(fif.inst_valid), 32'd0);
    chk("rd_new_addr", fif.mem_addr, 32'h100);
    chk("rd_new_req", 32'(fif.mem_req), 32'd1);
    tick();
    chk("rd_first_valid", 32'(fif.inst_valid), 32'd1);
    chk("rd_first_pc", fif.inst_pc, 32'h100);
    chk("rd_first_data", fif.inst_data, 32'hA5A5_0100);

    // 4. Redirect coincident with ack, unaligned target
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'h102;
    tick();
    fif.redirect_valid = 1'b0;
    chk("co_flush_valid", 32'(fif.inst_valid), 32'd0);
    chk("co_addr", fif.mem_addr, 32'h100);
    chk("co_req", 32'(fif.mem_req), 32'd1);
    tick();
    chk("co_first_pc", fif.inst_pc, 32'h100);
    chk("co_first_valid", 32'(fif.inst_valid), 32'd1);

    // 5. PC wrap
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'hFFFF_FFFC;
    tick();
    fif.redirect_valid = 1'b0;
    chk("wr_addr", fif.mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc_top", fif.inst_pc, 32'hFFFF_FFFC);
    chk("wr_data_top", fif.inst_data, 32'h5A5A_FFFC);
    chk("wr_addr_wrapped", fif.mem_addr, 32'h0);
    tick();
    chk("wr_pc_zero", fif.inst_pc, 32'h0);
    chk("wr_data_zero", fif.inst_data, 32'hA5A5_0000);

    // 6. Asynchronous reset mid-request
    fif.mem_ack = 1'b0;
    chk("ar_req_before", 32'(fif.mem_req), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_req_low", 32'(fif.mem_req), 32'd0);
    chk("ar_valid_low", 32'(fif.inst_valid), 32'd0);
    chk("ar_addr", fif.mem_addr, 32'h0);
    fif.mem_ack = 1'b1;
    tick();
    chk("ar_ack_in_reset", 32'(fif.mem_req), 32'd0);
    rst = 1'b0;
    tick();
    chk("ar_restart_req", 32'(fif.mem_req), 32'd1);
    chk("ar_restart_addr", fif.mem_addr, 32'h0);
    chk("ar_restart_no_valid", 32'(fif.inst_valid), 32'd0);
    tick();
    chk("ar_restart_pc", fif.inst_pc, 32'h0);
    chk("ar_restart_valid", 32'(fif.inst_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
